// File: rtl/entropy_cbc_mac_feeder.sv
// Packs raw entropy samples into one message, issues a single CBC-MAC request and
// forwards the returned MAC downstream on a valid/ready port.
module entropy_cbc_mac_feeder #(
   parameter int DATA_WIDTH     = 256,
   parameter int RAW_WIDTH      = 8,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  raw_valid_i,
   input  logic [RAW_WIDTH-1:0]  raw_data_i,
   output logic                  raw_ready_o,
   input  logic [127:0]          key_i,
   output logic                  mac_start_o,
   output logic [127:0]          mac_key_o,
   output logic [DATA_WIDTH-1:0] mac_message_o,
   input  logic                  mac_done_i,
   input  logic [DATA_WIDTH-1:0] mac_i,
   output logic                  out_valid_o,
   output logic [DATA_WIDTH-1:0] out_data_o,
   input  logic                  out_ready_i,
   output logic                  busy_o,
   output logic                  timeout_o
);

   localparam int SAMPLES = DATA_WIDTH / RAW_WIDTH;
   localparam int CNT_W   = (SAMPLES > 1) ? $clog2(SAMPLES) : 1;
   localparam int TMO_W   = $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] LAST_SAMPLE = CNT_W'(SAMPLES - 1);
   localparam logic [TMO_W-1:0] TMO_LAST    = TMO_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_COLLECT = 2'd0,
      ST_START   = 2'd1,
      ST_WAIT    = 2'd2,
      ST_HOLD    = 2'd3
   } state_e;

   state_e                state_q,     state_d;
   logic [CNT_W-1:0]      cnt_q,       cnt_d;
   logic [TMO_W-1:0]      tmo_q,       tmo_d;
   logic [DATA_WIDTH-1:0] msg_q,       msg_d;
   logic [127:0]          key_q,       key_d;
   logic [DATA_WIDTH-1:0] out_data_q,  out_data_d;
   logic                  out_valid_q, out_valid_d;
   logic                  timeout_q,   timeout_d;
   logic                  start_q,     start_d;
   logic                  ready_q,     ready_d;
   logic                  busy_q,      busy_d;
   logic                  accept_s;

   // Next-state and datapath updates; all outputs are derived from the next state so they register cleanly.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      tmo_d       = tmo_q;
      msg_d       = msg_q;
      key_d       = key_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      timeout_d   = timeout_q;
      accept_s    = 1'b0;

      case (state_q)
         ST_COLLECT: begin
            // ready_q is low for the first cycle after reset, so it gates acceptance too
            accept_s = raw_valid_i && ready_q;
            for (int k = 0; k < SAMPLES; k++) begin
               if (accept_s && (cnt_q == CNT_W'(k))) begin
                  msg_d[k*RAW_WIDTH +: RAW_WIDTH] = raw_data_i;
               end else begin
                  msg_d[k*RAW_WIDTH +: RAW_WIDTH] = msg_q[k*RAW_WIDTH +: RAW_WIDTH];
               end
            end
            if (accept_s) begin
               if (cnt_q == LAST_SAMPLE) begin
                  cnt_d   = {CNT_W{1'b0}};
                  key_d   = key_i;
                  state_d = ST_START;
               end else begin
                  cnt_d   = cnt_q + CNT_W'(1);
               end
            end else begin
               cnt_d = cnt_q;
            end
         end
         ST_START: begin
            tmo_d   = {TMO_W{1'b0}};
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (mac_done_i) begin
               out_data_d  = mac_i;
               out_valid_d = 1'b1;
               state_d     = ST_HOLD;
            end else if (tmo_q == TMO_LAST) begin
               timeout_d = 1'b1;
               state_d   = ST_COLLECT;
            end else begin
               tmo_d = tmo_q + TMO_W'(1);
            end
         end
         ST_HOLD: begin
            if (out_ready_i) begin
               out_valid_d = 1'b0;
               state_d     = ST_COLLECT;
            end else begin
               out_valid_d = 1'b1;
            end
         end
         default: begin
            state_d = ST_COLLECT;
         end
      endcase

      start_d = (state_d == ST_START);
      ready_d = (state_d == ST_COLLECT);
      busy_d  = (state_d != ST_COLLECT);
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_COLLECT;
         cnt_q       <= {CNT_W{1'b0}};
         tmo_q       <= {TMO_W{1'b0}};
         msg_q       <= {DATA_WIDTH{1'b0}};
         key_q       <= 128'd0;
         out_data_q  <= {DATA_WIDTH{1'b0}};
         out_valid_q <= 1'b0;
         timeout_q   <= 1'b0;
         start_q     <= 1'b0;
         ready_q     <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         tmo_q       <= tmo_d;
         msg_q       <= msg_d;
         key_q       <= key_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         timeout_q   <= timeout_d;
         start_q     <= start_d;
         ready_q     <= ready_d;
         busy_q      <= busy_d;
      end
   end

   assign raw_ready_o   = ready_q;
   assign mac_start_o   = start_q;
   assign mac_key_o     = key_q;
   assign mac_message_o = msg_q;
   assign out_valid_o   = out_valid_q;
   assign out_data_o    = out_data_q;
   assign busy_o        = busy_q;
   assign timeout_o     = timeout_q;

endmodule

// File: tb/tb_entropy_cbc_mac_feeder.sv
// Directed bench for entropy_cbc_mac_feeder with a transaction-level reference model
// and an every-cycle output comparator.
module tb_entropy_cbc_mac_feeder;

   localparam int DW      = 256;
   localparam int RW      = 8;
   localparam int TMO     = 64;
   localparam int SAMPLES = DW / RW;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          raw_valid_i;
   logic [RW-1:0] raw_data_i;
   logic          raw_ready_o;
   logic [127:0]  key_i;
   logic          mac_start_o;
   logic [127:0]  mac_key_o;
   logic [DW-1:0] mac_message_o;
   logic          mac_done_i;
   logic [DW-1:0] mac_i;
   logic          out_valid_o;
   logic [DW-1:0] out_data_o;
   logic          out_ready_i;
   logic          busy_o;
   logic          timeout_o;

   int checks = 0;
   int errors = 0;

   entropy_cbc_mac_feeder #(
      .DATA_WIDTH(DW), .RAW_WIDTH(RW), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .raw_valid_i(raw_valid_i), .raw_data_i(raw_data_i), .raw_ready_o(raw_ready_o),
      .key_i(key_i),
      .mac_start_o(mac_start_o), .mac_key_o(mac_key_o), .mac_message_o(mac_message_o),
      .mac_done_i(mac_done_i), .mac_i(mac_i),
      .out_valid_o(out_valid_o), .out_data_o(out_data_o), .out_ready_i(out_ready_i),
      .busy_o(busy_o), .timeout_o(timeout_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%h want=%h", name, act, exp);
      end
   endtask

   // Reference model: tracks collected samples, the outstanding request and the held result.
   bit            check_en = 1'b0;
   bit            m_ready, m_start, m_busy, m_valid, m_to, m_outstanding;
   logic [DW-1:0] m_msg, m_out;
   logic [127:0]  m_key;
   int            m_nsamp, m_waited;

   initial begin
      forever begin
         @(posedge clk);
         if (!rst_n) begin
            m_ready = 1'b0; m_start = 1'b0; m_busy = 1'b0; m_valid = 1'b0; m_to = 1'b0;
            m_outstanding = 1'b0; m_msg = '0; m_out = '0; m_key = '0;
            m_nsamp = 0; m_waited = 0; check_en = 1'b1;
         end else begin
            if (m_start) begin
               m_start = 1'b0; m_outstanding = 1'b1; m_waited = 0;
            end else if (m_outstanding) begin
               m_waited++;
               if (mac_done_i) begin
                  m_valid = 1'b1; m_out = mac_i; m_outstanding = 1'b0;
               end else if (m_waited == TMO) begin
                  m_to = 1'b1; m_outstanding = 1'b0;
               end
            end else if (m_valid) begin
               if (out_ready_i) m_valid = 1'b0;
            end else if (m_ready && raw_valid_i) begin
               m_msg[m_nsamp*RW +: RW] = raw_data_i;
               m_nsamp++;
               if (m_nsamp == SAMPLES) begin
                  m_nsamp = 0; m_key = key_i; m_start = 1'b1;
               end
            end
            m_busy  = m_start || m_outstanding || m_valid;
            m_ready = !m_busy;
         end
      end
   end

   // Comparator: every output against the model on every falling edge.
   initial begin
      forever begin
         @(negedge clk);
         if (check_en) begin
            chk("raw_ready", raw_ready_o, m_ready);
            chk("mac_start", mac_start_o, m_start);
            chk("busy", busy_o, m_busy);
            chk("out_valid", out_valid_o, m_valid);
            chk("out_data", out_data_o, m_out);
            chk("timeout", timeout_o, m_to);
            chk("mac_key", mac_key_o, m_key);
            chk("mac_message", mac_message_o, m_msg);
         end
      end
   end

   // Called at a falling edge; returns at the falling edge right after the last handshake.
   task automatic feed(input int n, input bit alt, input logic [7:0] base);
      for (int i = 0; i < n; i++) begin
         raw_valid_i = 1'b1;
         raw_data_i  = alt ? ((i % 2 == 0) ? 8'hFF : 8'h00) : base + 8'(i);
         @(negedge clk);
         if (alt && i < n - 1) begin
            raw_valid_i = 1'b0;
            raw_data_i  = 8'hC3;
            @(negedge clk);
         end
      end
      raw_valid_i = 1'b0;
   endtask

   // Engine answers 'delay' cycles after the start cycle; returns one cycle after done.
   task automatic answer(input int delay, input logic [DW-1:0] d, input bit rdy);
      repeat (delay) @(negedge clk);
      mac_done_i  = 1'b1;
      mac_i       = d;
      out_ready_i = rdy;
      @(negedge clk);
      mac_done_i  = 1'b0;
      mac_i       = '0;
   endtask

   initial begin
      rst_n = 1'b0; raw_valid_i = 1'b0; raw_data_i = 8'h00; key_i = '0;
      mac_done_i = 1'b0; mac_i = '0; out_ready_i = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_ready", raw_ready_o, 1'b0);
      chk("rst_busy", busy_o, 1'b0);
      chk("rst_timeout", timeout_o, 1'b0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("ready_after_rst", raw_ready_o, 1'b1);

      // 1: back-to-back stream 0x00..0x1F
      key_i = 128'h00112233445566778899AABBCCDDEEFF;
      feed(32, 1'b0, 8'h00);
      chk("t1_start", mac_start_o, 1'b1);
      chk("t1_msg", mac_message_o, 256'h1F1E1D1C1B1A191817161514131211100F0E0D0C0B0A09080706050403020100);
      chk("t1_key", mac_key_o, 128'h00112233445566778899AABBCCDDEEFF);
      chk("t1_ready", raw_ready_o, 1'b0);
      key_i = 128'hDEADBEEF_00000000_00000000_CAFEF00D;

      // 2: answer after 20 cycles, downstream stalls for 10 cycles
      answer(20, {32{8'hA5}}, 1'b0);
      chk("t2_valid", out_valid_o, 1'b1);
      chk("t2_data", out_data_o, {32{8'hA5}});
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("t2_hold_valid", out_valid_o, 1'b1);
         chk("t2_hold_data", out_data_o, {32{8'hA5}});
         chk("t2_hold_ready", raw_ready_o, 1'b0);
      end
      out_ready_i = 1'b1;
      @(negedge clk);
      out_ready_i = 1'b0;
      chk("t2_released", out_valid_o, 1'b0);
      chk("t2_ready_back", raw_ready_o, 1'b1);

      // 3: valid toggling, alternating FF/00 data
      feed(32, 1'b1, 8'h00);
      chk("t3_start", mac_start_o, 1'b1);
      chk("t3_msg", mac_message_o, {16{8'h00, 8'hFF}});
      chk("t3_key", mac_key_o, 128'hDEADBEEF_00000000_00000000_CAFEF00D);

      // 6: ready already high when valid rises
      answer(5, {8{32'h6A09E667}}, 1'b1);
      chk("t6_valid", out_valid_o, 1'b1);
      chk("t6_data", out_data_o, {8{32'h6A09E667}});
      @(negedge clk);
      out_ready_i = 1'b0;
      chk("t6_one_xfer", out_valid_o, 1'b0);
      chk("t6_ready", raw_ready_o, 1'b1);
      feed(1, 1'b0, 8'h77);
      chk("t6_first_byte", mac_message_o[7:0], 8'h77);
      feed(31, 1'b0, 8'h78);
      chk("t6_start", mac_start_o, 1'b1);

      // 4: engine never answers
      repeat (TMO) @(negedge clk);
      chk("t4_no_early_timeout", timeout_o, 1'b0);
      @(negedge clk);
      chk("t4_timeout", timeout_o, 1'b1);
      chk("t4_busy", busy_o, 1'b0);
      chk("t4_no_out", out_valid_o, 1'b0);
      mac_done_i = 1'b1;
      mac_i      = {DW{1'b1}};
      @(negedge clk);
      mac_done_i = 1'b0;
      mac_i      = '0;
      chk("t4_late_done", out_valid_o, 1'b0);
      chk("t4_late_busy", busy_o, 1'b0);
      feed(32, 1'b0, 8'h40);
      answer(3, {4{64'h0123456789ABCDEF}}, 1'b0);
      chk("t4_recover", out_data_o, {4{64'h0123456789ABCDEF}});
      out_ready_i = 1'b1;
      @(negedge clk);
      out_ready_i = 1'b0;
      chk("t4_sticky", timeout_o, 1'b1);

      // 5: reset during WAIT, stale done afterwards
      feed(32, 1'b0, 8'h20);
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("t5_timeout_clr", timeout_o, 1'b0);
      chk("t5_busy", busy_o, 1'b0);
      chk("t5_ready", raw_ready_o, 1'b0);
      chk("t5_msg_clr", mac_message_o, '0);
      rst_n      = 1'b1;
      mac_done_i = 1'b1;
      mac_i      = {DW{1'b1}};
      @(negedge clk);
      mac_done_i = 1'b0;
      mac_i      = '0;
      chk("t5_stale_done", out_valid_o, 1'b0);
      chk("t5_ready_back", raw_ready_o, 1'b1);
      feed(32, 1'b0, 8'h80);
      chk("t5_start", mac_start_o, 1'b1);
      chk("t5_msg", mac_message_o, 256'h9F9E9D9C9B9A999897969594939291908F8E8D8C8B8A89888786858483828180);
      answer(2, {16{16'h5EED}}, 1'b1);
      chk("t5_data", out_data_o, {16{16'h5EED}});
      @(negedge clk);
      out_ready_i = 1'b0;
      repeat (3) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
